pipeline_hazard_controller: RTL and testbench

- Issue controller between the decode stage and execute of the 24-bit vector/scalar ASIP pipeline.
- Tracks in-flight register writes in a scoreboard, and in-flight NZ-flag writers in a counter.
- Stalls decode on RAW/WAW hazards and on conditional jumps whose NZ flags are not yet settled.
- Flushes the wrong-path slots after any PC-redirecting instruction issues.

---
 rtl/pipeline_hazard_controller.sv | 94 +++++++++
 tb/tb_pipeline_hazard_controller.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
// Issue controller between decode and execute: scoreboards in-flight register
// writes and NZ-flag writers, stalls on hazards and flushes after PC redirects.
module pipeline_hazard_controller #(
    parameter int NUM_REGS    = 16,
    parameter int FLUSH_DEPTH = 2,
    parameter int NZ_CNT_W    = 3,
    localparam int IDX_W      = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [IDX_W-1:0]    id_rs_a,
    input  logic                id_rs_a_used,
    input  logic [IDX_W-1:0]    id_rs_b,
    input  logic                id_rs_b_used,
    input  logic [IDX_W-1:0]    id_rd,
    input  logic                id_reg_write,
    input  logic                id_overwrite_nz,
    input  logic [2:0]          id_pc_write_en,
    input  logic                wb_valid,
    input  logic [IDX_W-1:0]    wb_rd,
    input  logic                wb_nz,
    output logic                issue,
    output logic                stall,
    output logic                flush,
    output logic [NUM_REGS-1:0] pending,
    output logic                nz_busy,
    output logic                proto_err
);

    logic [NZ_CNT_W-1:0] nz_cnt;
    logic [2:0]          flush_cnt;

    logic                flushing;
    logic                hazard;
    logic                nz_inc;
    logic                nz_dec;
    logic                underflow;
    logic                retire_err;
    logic                redirect;
    logic [NUM_REGS-1:0] set_vec;
    logic [NUM_REGS-1:0] clr_vec;

    // Hazard checks use the registered scoreboard only, so a retire this cycle
    // cannot unblock a reader until the next cycle.
    always_comb begin
        flushing = (flush_cnt != 3'd0);
        nz_busy  = |nz_cnt;
        hazard   = (id_rs_a_used & pending[id_rs_a])
                 | (id_rs_b_used & pending[id_rs_b])
                 | (id_reg_write & pending[id_rd])
                 | (id_pc_write_en[2] & nz_busy)
                 | (id_overwrite_nz & (&nz_cnt));
        issue    = id_valid & ~flushing & ~hazard;
        stall    = id_valid & ~flushing & hazard;
        flush    = flushing;
        redirect = issue & (|id_pc_write_en);
    end

    always_comb begin
        set_vec    = (issue & id_reg_write) ? (NUM_REGS'(1) << id_rd) : '0;
        clr_vec    = wb_valid ? (NUM_REGS'(1) << wb_rd) : '0;
        nz_inc     = issue & id_overwrite_nz;
        nz_dec     = wb_valid & wb_nz;
        underflow  = nz_dec & ~nz_inc & ~nz_busy;
        retire_err = wb_valid & ~pending[wb_rd] & ~set_vec[wb_rd];
    end

    // Set is applied after clear so a new writer wins over a same-cycle retire.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending   <= '0;
            nz_cnt    <= '0;
            flush_cnt <= 3'd0;
            proto_err <= 1'b0;
        end else begin
            pending <= (pending & ~clr_vec) | set_vec;
            if (nz_inc & ~nz_dec) begin
                nz_cnt <= nz_cnt + NZ_CNT_W'(1);
            end else if (nz_dec & ~nz_inc & nz_busy) begin
                nz_cnt <= nz_cnt - NZ_CNT_W'(1);
            end
            if (redirect) begin
                flush_cnt <= 3'(FLUSH_DEPTH);
            end else if (flushing) begin
                flush_cnt <= flush_cnt - 3'd1;
            end
            if (retire_err | underflow) begin
                proto_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_pipeline_hazard_controller;

    localparam int FLUSH_DEPTH = 2;
    localparam int NZ_MAX      = 7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        id_valid = 1'b0;
    logic [3:0]  id_rs_a = 4'd0;
    logic        id_rs_a_used = 1'b0;
    logic [3:0]  id_rs_b = 4'd0;
    logic        id_rs_b_used = 1'b0;
    logic [3:0]  id_rd = 4'd0;
    logic        id_reg_write = 1'b0;
    logic        id_overwrite_nz = 1'b0;
    logic [2:0]  id_pc_write_en = 3'd0;
    logic        wb_valid = 1'b0;
    logic [3:0]  wb_rd = 4'd0;
    logic        wb_nz = 1'b0;
    logic        issue;
    logic        stall;
    logic        flush;
    logic [15:0] pending;
    logic        nz_busy;
    logic        proto_err;

    int tests_run    = 0;
    int tests_failed = 0;

    // Behavioural model state
    bit m_pend [16];
    int m_nz;
    int m_flush;
    bit m_err;
    bit m_ok = 1'b0;

    pipeline_hazard_controller #(
        .NUM_REGS(16), .FLUSH_DEPTH(FLUSH_DEPTH), .NZ_CNT_W(3)
    ) dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_rs_a(id_rs_a), .id_rs_a_used(id_rs_a_used),
        .id_rs_b(id_rs_b), .id_rs_b_used(id_rs_b_used), .id_rd(id_rd),
        .id_reg_write(id_reg_write), .id_overwrite_nz(id_overwrite_nz),
        .id_pc_write_en(id_pc_write_en), .wb_valid(wb_valid), .wb_rd(wb_rd),
        .wb_nz(wb_nz), .issue(issue), .stall(stall), .flush(flush),
        .pending(pending), .nz_busy(nz_busy), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] ra, input logic rau,
                                 input logic [3:0] rb, input logic rbu,
                                 input logic [3:0] rd, input logic rw, input logic onz,
                                 input logic [2:0] pcw, input logic wv,
                                 input logic [3:0] wrd, input logic wnz);
        @(posedge clk);
        #2;
        id_valid = v; id_rs_a = ra; id_rs_a_used = rau; id_rs_b = rb; id_rs_b_used = rbu;
        id_rd = rd; id_reg_write = rw; id_overwrite_nz = onz; id_pc_write_en = pcw;
        wb_valid = wv; wb_rd = wrd; wb_nz = wnz;
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0);
    endtask

    task automatic tickReset(input logic r);
        @(posedge clk);
        #2;
        rst = r;
        id_valid = 0; id_rs_a_used = 0; id_rs_b_used = 0; id_reg_write = 0;
        id_overwrite_nz = 0; id_pc_write_en = 3'b000; wb_valid = 0; wb_nz = 0;
        #1;
    endtask

    // Compare process: outputs are stable at the falling edge; the model then
    // advances to the state the DUT will hold after the next rising edge.
    always @(negedge clk) begin
        bit flushing, haz, e_issue, e_stall, inc, dec;
        logic [15:0] e_pend;
        flushing = (m_flush > 0);
        haz = (id_rs_a_used && m_pend[id_rs_a]) || (id_rs_b_used && m_pend[id_rs_b])
           || (id_reg_write && m_pend[id_rd]) || (id_pc_write_en[2] && m_nz > 0)
           || (id_overwrite_nz && m_nz == NZ_MAX);
        e_issue = id_valid && !flushing && !haz;
        e_stall = id_valid && !flushing && haz;
        if (m_ok) begin
            for (int i = 0; i < 16; i++) e_pend[i] = m_pend[i];
            checkOutput("issue", 32'(issue), 32'(e_issue));
            checkOutput("stall", 32'(stall), 32'(e_stall));
            checkOutput("flush", 32'(flush), 32'(flushing));
            checkOutput("nz_busy", 32'(nz_busy), 32'(m_nz > 0));
            checkOutput("pending", 32'(pending), 32'(e_pend));
            checkOutput("proto_err", 32'(proto_err), 32'(m_err));
        end
        if (rst) begin
            for (int i = 0; i < 16; i++) m_pend[i] = 1'b0;
            m_nz = 0; m_flush = 0; m_err = 1'b0; m_ok = 1'b1;
        end else if (m_ok) begin
            if (wb_valid) begin
                if (!m_pend[wb_rd] && !(e_issue && id_reg_write && id_rd == wb_rd)) m_err = 1'b1;
                m_pend[wb_rd] = 1'b0;
            end
            if (e_issue && id_reg_write) m_pend[id_rd] = 1'b1;
            inc = e_issue && id_overwrite_nz;
            dec = wb_valid && wb_nz;
            if (inc && !dec) m_nz++;
            else if (dec && !inc) begin
                if (m_nz == 0) m_err = 1'b1;
                else m_nz--;
            end
            if (e_issue && id_pc_write_en != 3'b000) m_flush = FLUSH_DEPTH;
            else if (m_flush > 0) m_flush--;
        end
    end

    initial begin
        // Reset state
        tickReset(1);
        tickReset(1);
        checkOutput("rst_issue", 32'(issue), 0);
        checkOutput("rst_stall", 32'(stall), 0);
        checkOutput("rst_flush", 32'(flush), 0);
        checkOutput("rst_nz_busy", 32'(nz_busy), 0);
        checkOutput("rst_pending", 32'(pending), 0);
        checkOutput("rst_proto_err", 32'(proto_err), 0);
        tickReset(0);

        // First issue of a register writer
        applyStimulus(1, 0, 0, 0, 0, 4'd3, 1, 0, 3'b000, 0, 0, 0);
        checkOutput("first_issue", 32'(issue), 1);
        idleCycle();
        checkOutput("first_pending", 32'(pending), 32'h0008);

        // RAW with retire bypass rule
        applyStimulus(1, 4'd3, 1, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0);
        checkOutput("raw_stall", 32'(stall), 1);
        checkOutput("raw_no_issue", 32'(issue), 0);
        applyStimulus(1, 4'd3, 1, 0, 0, 0, 0, 0, 3'b000, 1, 4'd3, 0);
        checkOutput("raw_stall_at_retire", 32'(stall), 1);
        applyStimulus(1, 4'd3, 1, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0);
        checkOutput("raw_issue_after", 32'(issue), 1);
        checkOutput("raw_pending_clear", 32'(pending), 0);

        // WAW stall, then same-cycle set/clear on a free register
        applyStimulus(1, 0, 0, 0, 0, 4'd5, 1, 0, 3'b000, 0, 0, 0);
        checkOutput("r5_issue", 32'(issue), 1);
        applyStimulus(1, 0, 0, 0, 0, 4'd5, 1, 0, 3'b000, 1, 4'd5, 0);
        checkOutput("waw_stall", 32'(stall), 1);
        applyStimulus(1, 0, 0, 0, 0, 4'd5, 1, 0, 3'b000, 1, 4'd5, 0);
        checkOutput("setclr_issue", 32'(issue), 1);
        idleCycle();
        checkOutput("setclr_pending", 32'(pending), 32'h0020);
        checkOutput("setclr_no_err", 32'(proto_err), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1, 4'd5, 0);

        // Conditional jump waits for NZ, then a two-cycle flush
        applyStimulus(1, 0, 0, 0, 0, 4'd7, 1, 1, 3'b000, 0, 0, 0);
        checkOutput("nz_writer_issue", 32'(issue), 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 3'b100, 0, 0, 0);
        checkOutput("cj_stall", 32'(stall), 1);
        checkOutput("cj_nz_busy", 32'(nz_busy), 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 3'b100, 1, 4'd7, 1);
        checkOutput("cj_stall_at_retire", 32'(stall), 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 3'b100, 0, 0, 0);
        checkOutput("cj_issue", 32'(issue), 1);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0);
            checkOutput("flush_on", 32'(flush), 1);
            checkOutput("flush_no_issue", 32'(issue), 0);
            checkOutput("flush_no_stall", 32'(stall), 0);
        end
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0);
        checkOutput("flush_done", 32'(flush), 0);
        checkOutput("flush_resume_issue", 32'(issue), 1);

        // NZ counter saturation
        for (int k = 1; k <= 7; k++) begin
            applyStimulus(1, 0, 0, 0, 0, 4'(k), 1, 1, 3'b000, 0, 0, 0);
            checkOutput("nz_fill_issue", 32'(issue), 1);
        end
        applyStimulus(1, 0, 0, 0, 0, 4'd8, 1, 1, 3'b000, 0, 0, 0);
        checkOutput("nz_full_stall", 32'(stall), 1);
        applyStimulus(1, 0, 0, 0, 0, 4'd8, 1, 1, 3'b000, 1, 4'd1, 1);
        checkOutput("nz_full_stall_at_retire", 32'(stall), 1);
        applyStimulus(1, 0, 0, 0, 0, 4'd8, 1, 1, 3'b000, 0, 0, 0);
        checkOutput("nz_eighth_issue", 32'(issue), 1);
        applyStimulus(1, 0, 0, 0, 0, 4'd9, 1, 1, 3'b000, 0, 0, 0);
        checkOutput("nz_back_to_max", 32'(stall), 1);
        for (int k = 2; k <= 8; k++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1, 4'(k), 1);
        idleCycle();
        checkOutput("nz_drained", 32'(nz_busy), 0);
        checkOutput("drained_pending", 32'(pending), 0);
        checkOutput("drained_no_err", 32'(proto_err), 0);

        // Protocol error and reset mid-flush
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 1, 4'd9, 0);
        idleCycle();
        checkOutput("err_set", 32'(proto_err), 1);
        idleCycle();
        checkOutput("err_sticky", 32'(proto_err), 1);
        applyStimulus(1, 0, 0, 0, 0, 4'd2, 1, 0, 3'b001, 0, 0, 0);
        checkOutput("mi_jump_issue", 32'(issue), 1);
        idleCycle();
        checkOutput("mi_flush", 32'(flush), 1);
        checkOutput("mi_pending", 32'(pending), 32'h0004);
        tickReset(1);
        tickReset(0);
        checkOutput("rst_mid_flush", 32'(flush), 0);
        checkOutput("rst_mid_pending", 32'(pending), 0);
        checkOutput("rst_mid_err", 32'(proto_err), 0);

        // Randomized traffic, biased toward a few registers to provoke hazards
        for (int c = 0; c < 3000; c++) begin
            int r;
            logic [3:0] wrd;
            logic wv, wnz;
            r = int'($urandom_range(0, 199));
            if (r == 0) begin
                tickReset(1);
                tickReset(0);
            end else begin
                wv = ($urandom_range(0, 2) == 0);
                wrd = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 19) != 0) begin
                    int off;
                    off = int'($urandom_range(0, 15));
                    for (int i = 0; i < 16; i++) begin
                        if (m_pend[(off + i) % 16]) begin
                            wrd = 4'((off + i) % 16);
                            break;
                        end
                    end
                end
                wnz = wv && ((m_nz > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 29) == 0));
                applyStimulus($urandom_range(0, 3) != 0,
                              4'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
                              4'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
                              4'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                              ($urandom_range(0, 2) == 0),
                              ($urandom_range(0, 9) == 0) ? (3'b001 << $urandom_range(0, 2)) : 3'b000,
                              wv, wrd, wnz);
            end
        end
        idleCycle();
        idleCycle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
